// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the round sequencer and its timer.
package game_pkg;

    localparam int unsigned VAL_W          = 8;
    localparam int unsigned SCORE_W        = 8;
    localparam int unsigned LIVES_INIT     = 3;
    localparam int unsigned ROUNDS_PER_LVL = 4;
    localparam int unsigned LVL_MAX        = 7;
    localparam int unsigned BASE_TIME      = 10;
    localparam int unsigned MIN_TIME       = 3;
    localparam int unsigned TIME_W         = 8;
    localparam int unsigned LIVES_W        = 2;
    localparam int unsigned LVL_W          = 3;
    localparam int unsigned RND_W          = $clog2(ROUNDS_PER_LVL + 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        LATCH,
        WAIT,
        JUDGE,
        OVER
    } state_e;

    // Score add that clamps at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_sat_add(input logic [SCORE_W-1:0] a,
                                                         input logic [1:0]         inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W - 1){1'b0}}, inc};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    // Round length shrinks by one tick per level down to a floor.
    function automatic logic [TIME_W-1:0] round_time_for(input logic [LVL_W-1:0] lvl);
        if (BASE_TIME < MIN_TIME + 32'(lvl)) begin
            return TIME_W'(MIN_TIME);
        end
        return TIME_W'(BASE_TIME - 32'(lvl));
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Bus between the round sequencer and the controller / RNG / player-entry side.
interface round_sequencer_if;
    import game_pkg::*;

    logic                game_active;
    logic                tick;
    logic                rng_req;
    logic [VAL_W-1:0]    rng_value;
    logic                player_load;
    logic [VAL_W-1:0]    player_value;
    logic [VAL_W-1:0]    target;
    logic [TIME_W-1:0]   round_time;
    logic [SCORE_W-1:0]  score;
    logic [LIVES_W-1:0]  lives;
    logic [LVL_W-1:0]    level;
    logic                hit;
    logic                miss;
    logic                game_over;

    modport master (
        input  game_active, tick, rng_value, player_load, player_value,
        output rng_req, target, round_time, score, lives, level, hit, miss, game_over
    );

    modport slave (
        output game_active, tick, rng_value, player_load, player_value,
        input  rng_req, target, round_time, score, lives, level, hit, miss, game_over
    );

endinterface

// File: rtl/round_timer.sv
// Loadable per-round countdown; stops at zero and flags the tick that reaches it.
module round_timer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_val_i,
    input  logic              tick_i,
    output logic [TIME_W-1:0] count_o,
    output logic              expire_c
);

    logic [TIME_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && count_q != '0) begin
            count_d = count_q - TIME_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_c = tick_i && !load_i && (count_q == TIME_W'(1));

endmodule

// File: rtl/round_sequencer.sv
// Per-round game sequencing: draw target, count down, judge entry, keep score/lives/level.
// Optional STREAK_BONUS_EN: third and later consecutive hits score 2 instead of 1.
module round_sequencer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    round_sequencer_if.master bus
);

    state_e               state_q, state_d;
    logic [VAL_W-1:0]     target_q, target_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [RND_W-1:0]     rounds_q, rounds_d;
    logic                 rng_req_q, rng_req_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 game_over_q, game_over_d;
    logic                 timer_load_c, timer_tick_c, timer_expire_c;
    logic [TIME_W-1:0]    round_time;
    logic [1:0]           bonus_c;

    // An entry on the same cycle as the final tick wins, so the tick never reaches the timer.
    assign timer_load_c = (state_q == LATCH) && bus.game_active;
    assign timer_tick_c = (state_q == WAIT) && bus.game_active && bus.tick && !bus.player_load;

    round_timer u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load_c),
        .load_val_i (round_time_for(level_q)),
        .tick_i     (timer_tick_c),
        .count_o    (round_time),
        .expire_c   (timer_expire_c)
    );

`ifdef STREAK_BONUS_EN
    logic [1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE && bus.game_active) begin
            streak_d = '0;
        end else if (hit_d) begin
            streak_d = (streak_q == 2'd3) ? streak_q : streak_q + 2'd1;
        end else if (miss_d) begin
            streak_d = '0;
        end
    end

    assign bonus_c = (streak_q >= 2'd2) ? 2'd2 : 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign bonus_c = 2'd1;
`endif

    // Next state plus judgement; score/lives/level update together with the hit/miss pulse.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        score_d  = score_q;
        lives_d  = lives_q;
        level_d  = level_q;
        rounds_d = rounds_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        if (!bus.game_active && state_q != IDLE && state_q != OVER) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.game_active) begin
                        score_d  = '0;
                        level_d  = '0;
                        rounds_d = '0;
                        lives_d  = LIVES_W'(LIVES_INIT);
                        state_d  = DRAW;
                    end
                end
                DRAW:  state_d = LATCH;
                LATCH: begin
                    target_d = bus.rng_value;
                    state_d  = WAIT;
                end
                WAIT: begin
                    if (bus.player_load) begin
                        hit_d   = (bus.player_value == target_q);
                        miss_d  = (bus.player_value != target_q);
                        state_d = JUDGE;
                    end else if (timer_expire_c) begin
                        miss_d  = 1'b1;
                        state_d = JUDGE;
                    end
                    if (hit_d) begin
                        score_d = score_sat_add(score_q, bonus_c);
                        if (rounds_q == RND_W'(ROUNDS_PER_LVL - 1)) begin
                            rounds_d = '0;
                            if (level_q != LVL_W'(LVL_MAX)) begin
                                level_d = level_q + LVL_W'(1);
                            end
                        end else begin
                            rounds_d = rounds_q + RND_W'(1);
                        end
                    end
                    if (miss_d) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end
                JUDGE: state_d = (lives_q == '0) ? OVER : DRAW;
                OVER: begin
                    if (!bus.game_active) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rng_req_d   = (state_d == DRAW);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_W'(LIVES_INIT);
            level_q     <= '0;
            rounds_q    <= '0;
            rng_req_q   <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            rounds_q    <= rounds_d;
            rng_req_q   <= rng_req_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.rng_req    = rng_req_q;
    assign bus.target     = target_q;
    assign bus.round_time = round_time;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.level      = level_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed/randomized bench for round_sequencer against a score/lives/level model.
module tb_round_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_sequencer_if bus ();

    round_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int         m_score, m_lives, m_level, m_rounds, m_streak;
    int         cur_time;
    logic [7:0] cur_target;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int exp_time();
        return (10 - m_level < 3) ? 3 : 10 - m_level;
    endfunction

    task automatic new_game();
        m_score = 0; m_lives = 3; m_level = 0; m_rounds = 0; m_streak = 0;
    endtask

    task automatic model_hit();
        int inc;
        inc = 1;
`ifdef STREAK_BONUS_EN
        if (m_streak >= 2) inc = 2;
        m_streak = (m_streak == 3) ? 3 : m_streak + 1;
`endif
        m_score = (m_score + inc > 255) ? 255 : m_score + inc;
        m_rounds++;
        if (m_rounds == 4) begin
            m_rounds = 0;
            if (m_level < 7) m_level++;
        end
    endtask

    task automatic model_miss();
        m_lives--;
        m_streak = 0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_score"}, bus.score, m_score);
        check({tag, "_lives"}, bus.lives, m_lives);
        check({tag, "_level"}, bus.level, m_level);
    endtask

    // Expects to be at the negedge of the DRAW cycle.
    task automatic draw(input logic [7:0] v);
        check("rng_req_draw", bus.rng_req, 1);
        bus.rng_value = v;
        cyc();
        check("rng_req_one_cycle", bus.rng_req, 0);
        cyc();
        bus.rng_value = 8'($urandom);
        cur_target = v;
        cur_time   = exp_time();
        check("target_latch", bus.target, v);
        check("round_time_load", bus.round_time, cur_time);
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cur_time--;
        check("round_time_dec", bus.round_time, cur_time);
        check("no_pulse_in_wait", {bus.hit, bus.miss}, 2'b00);
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic after_judge();
        cyc();
        check("pulse_one_cycle", {bus.hit, bus.miss}, 2'b00);
        if (m_lives == 0) check("game_over_set", bus.game_over, 1);
        else              check("rng_req_after_judge", bus.rng_req, 1);
    endtask

    task automatic enter(input logic [7:0] val, input bit with_tick);
        bit good;
        good = (val == cur_target);
        bus.player_load  = 1'b1;
        bus.player_value = val;
        bus.tick         = with_tick;
        cyc();
        bus.player_load  = 1'b0;
        bus.tick         = 1'b0;
        bus.player_value = 8'($urandom);
        if (good) model_hit();
        else      model_miss();
        check("hit", bus.hit, good);
        check("miss", bus.miss, !good);
        check("round_time_hold", bus.round_time, cur_time);
        check_stats("judge");
        after_judge();
    endtask

    task automatic play(input bit good, input int nticks);
        logic [7:0] val;
        draw(8'($urandom));
        for (int i = 0; i < nticks && cur_time > 1; i++) tick_once();
        val = good ? cur_target : cur_target ^ 8'($urandom_range(1, 255));
        enter(val, 1'b0);
    endtask

    task automatic timeout_round();
        draw(8'($urandom));
        while (cur_time > 1) tick_once();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        model_miss();
        cur_time = 0;
        check("timeout_miss", bus.miss, 1);
        check("timeout_no_hit", bus.hit, 0);
        check("timeout_round_time", bus.round_time, 0);
        check_stats("timeout");
        after_judge();
    endtask

    initial begin
        rst = 1'b0;
        bus.game_active  = 1'b0;
        bus.tick         = 1'b0;
        bus.rng_value    = '0;
        bus.player_load  = 1'b0;
        bus.player_value = '0;
        new_game();
        repeat (3) cyc();
        check("rst_score", bus.score, 0);
        check("rst_lives", bus.lives, 3);
        check("rst_level", bus.level, 0);
        check("rst_target", bus.target, 0);
        check("rst_round_time", bus.round_time, 0);
        check("rst_outputs", {bus.rng_req, bus.hit, bus.miss, bus.game_over}, 4'b0000);
        rst = 1'b1;
        cyc();
        check("idle_no_req", bus.rng_req, 0);

        // First round with a fixed target, answered after two ticks
        bus.game_active = 1'b1;
        new_game();
        cyc();
        draw(8'hA5);
        tick_once();
        tick_once();
        enter(8'hA5, 1'b0);

        // Level step after four hits, then a wrong entry
        repeat (3) play(1'b1, $urandom_range(0, 3));
        play(1'b0, 1);

        // Entry on the same cycle as the final tick
        draw(8'($urandom));
        while (cur_time > 1) tick_once();
        enter(cur_target, 1'b1);

        // Run score and level into saturation
        while (!(m_score == 255 && m_level == 7)) play(1'b1, 0);
        repeat (2) play(1'b1, 0);

        // Drop game_active mid-round: no pulse, stats and timer hold
        draw(8'($urandom));
        tick_once();
        bus.game_active = 1'b0;
        cyc();
        check("drop_no_pulse", {bus.hit, bus.miss}, 2'b00);
        check("drop_no_req", bus.rng_req, 0);
        check_stats("drop");
        bus.player_load  = 1'b1;
        bus.player_value = cur_target;
        bus.tick         = 1'b1;
        cyc();
        bus.player_load  = 1'b0;
        bus.tick         = 1'b0;
        check("idle_load_ignored", {bus.hit, bus.miss}, 2'b00);
        check("idle_round_time_hold", bus.round_time, cur_time);
        repeat (3) cyc();
        check("idle_no_req_later", bus.rng_req, 0);

        // Fresh game, three timeouts to game over
        bus.game_active = 1'b1;
        new_game();
        cyc();
        check_stats("restart");
        check("restart_req", bus.rng_req, 1);
        repeat (3) timeout_round();
        repeat (4) cyc();
        check("over_hold", bus.game_over, 1);
        check("over_no_req", bus.rng_req, 0);
        check_stats("over");
        bus.game_active = 1'b0;
        cyc();
        check("over_cleared", bus.game_over, 0);

        // Asynchronous reset in the middle of a round
        bus.game_active = 1'b1;
        new_game();
        cyc();
        repeat (3) play(1'b1, 0);
        draw(8'($urandom));
        repeat (5) tick_once();
        check("pre_rst_round_time", bus.round_time, 5);
        #2;
        rst = 1'b0;
        bus.game_active = 1'b0;
        #1;
        new_game();
        check_stats("async_rst");
        check("async_rst_target", bus.target, 0);
        check("async_rst_round_time", bus.round_time, 0);
        check("async_rst_outputs", {bus.rng_req, bus.hit, bus.miss, bus.game_over}, 4'b0000);
        cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_idle", bus.rng_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Sequences individual rounds inside the Game_Play phase of the game flow.
- Per round it:
  - requests a random target from the RNG;
  - runs a per-round countdown;
  - captures the player's entered binary value;
  - judges the entry and updates score, lives and level.
- Sits between the top-level game controller (game_active) and the RNG and player-entry datapath.
- Asserts game_over when lives run out; this drives the controller's DigitTime_Out input.

Parameters:
- VAL_W, 8, width of target and player values
- SCORE_W, 8, score width (saturating)
- LIVES_INIT, 3, lives at game start
- ROUNDS_PER_LVL, 4, correct answers needed per level step
- LVL_MAX, 7, highest level
- BASE_TIME, 10, round time in ticks at level 0
- MIN_TIME, 3, lower bound on round time

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- game_active  in  1  high while controller is in Game_Play
- tick  in  1  one-cycle timebase pulse (1 Hz)
- rng_req  out  1  one-cycle request for a new random value
- rng_value  in  VAL_W  RNG output, valid the cycle after rng_req
- player_load  in  1  one-cycle strobe: player committed an entry
- player_value  in  VAL_W  player entry, sampled on player_load
- target  out  VAL_W  current round target (for display)
- round_time  out  8  ticks remaining in round
- score  out  SCORE_W  current score
- lives  out  2  lives remaining
- level  out  3  current level
- hit  out  1  one-cycle pulse: correct answer
- miss  out  1  one-cycle pulse: wrong answer or timeout
- game_over  out  1  level, high from OVER until game_active drops

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - All outputs 0, except lives = LIVES_INIT.
  - Internal round counter = 0, streak counter = 0.
- States: IDLE, DRAW, LATCH, WAIT, JUDGE, OVER.
- IDLE:
  - Outputs hold their values.
  - On game_active=1: clear score, level and round counter; set lives = LIVES_INIT; go to DRAW.
- DRAW: rng_req=1 for exactly one cycle; go to LATCH.
- LATCH:
  - target <= rng_value.
  - round_time <= max(BASE_TIME - level, MIN_TIME).
  - Go to WAIT.
- WAIT:
  - player_load=1: latch player_value; go to JUDGE.
  - Otherwise, tick=1 with round_time>1: decrement round_time.
  - Otherwise, tick=1 with round_time==1: round_time <= 0; timeout; go to JUDGE flagged as a miss.
  - player_load and a timeout tick in the same cycle: player_load wins, tick ignored.
  - player_load outside WAIT is ignored.
- JUDGE (one cycle; the hit/miss pulse is asserted in this cycle):
  - Correct (entry == target):
    - score += 1, saturating at 2^SCORE_W-1;
    - round counter += 1;
    - when round counter reaches ROUNDS_PER_LVL it clears, and level increments (saturating at LVL_MAX).
  - Miss: lives -= 1; streak clears.
  - If lives becomes 0: go to OVER. Otherwise go to DRAW.
  - Next DRAW follows JUDGE with zero idle cycles.
  - Latency: player_load to hit/miss = 1 cycle; hit/miss to next rng_req = 1 cycle.
- OVER: game_over=1; score, level and target hold; go to IDLE when game_active=0.
- game_active falling in any state other than IDLE or OVER:
  - go to IDLE next cycle;
  - no hit/miss pulse;
  - score, lives and level hold;
  - rng_req never asserted after the drop.
- game_active rising again restarts a fresh game via IDLE.
- round_time never underflows. It does not decrement while game_active=0.

Optional Feature:
- STREAK_BONUS_EN defined:
  - a 2-bit streak counter increments on each hit, saturating at 3;
  - a hit with streak already ≥2 (third and later consecutive hit) adds 2 to score instead of 1, still saturating.
- Undefined: no streak counter; every hit adds 1.

Decomposition:
- Shared package game_pkg:
  - state encoding enum (IDLE..OVER);
  - LIVES_INIT, BASE_TIME, MIN_TIME constants;
  - score saturating-add function.
- One natural sub-module, round_timer: load value, tick, decrement and expiry pulse, instantiated for round_time.
- FSM, scoring and level logic stay in round_sequencer.

Test Plan:
- Reset mid-WAIT with round_time=5 and score=3 -> all outputs 0, lives=3, state IDLE in the same cycle rst falls.
- Start game, rng_value=8'hA5; player_load with 8'hA5 two ticks later -> hit one cycle after the strobe, score=1, rng_req one cycle after hit, round_time reloaded to 10.
- Four consecutive hits -> level=1, next round_time=9. Drive to level 7 -> round_time=3 and level saturates at 7.
- No entry for 10 ticks -> round_time 10→0, miss pulse, lives=2. Repeat twice more -> game_over=1 after the third miss, cleared when game_active=0.
- player_load and final tick in the same cycle with a correct value -> hit, no miss, lives unchanged.
- STREAK_BONUS_EN defined, three consecutive hits -> score 1, 2, 4. Then a miss, then a hit -> score 5.
